// File: rtl/cpu_writeback_pkg.sv
// Shared CPU pipeline types used by the writeback stage and the debug trace path.
// Combinational-only definitions; no latency.
// No handshakes are defined here.
package cpu_writeback_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [XLEN-1:0]      register_t;
    typedef logic [REG_IDX_W-1:0] reg_index_t;

    typedef struct packed {
        register_t  pc;
        register_t  rd;
        reg_index_t inst_rd;
        logic       strobe;
    } memory_data_t;

    typedef struct packed {
        register_t  pc;
        reg_index_t rd_index;
        register_t  rd_value;
    } trace_record_t;

    localparam int TRACE_REC_W = $bits(trace_record_t);

endpackage

// File: rtl/cpu_trace_fifo.sv
// Synchronous FIFO with count-based full/empty and head read straight from storage flops.
// Latency: a push is visible at the head one clock later.
// Backpressure: pushes while full are dropped; full ignores a same-cycle pop.
module cpu_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_full,
    output logic             o_pop_vld,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_pop_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (count_q == CNT_W'(DEPTH));
    assign o_pop_vld = (count_q != '0);
    assign o_pop_dat = mem_q[rd_ptr_q];
    assign push      = i_push_vld && !o_full;
    assign pop       = i_pop_rdy && o_pop_vld;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: retires memory-stage packets into the register file, forwarding copy, instret and trace FIFO.
// Latency: one clock from accept to register-file write, instret update and trace head.
// Backpressure: a pending packet stalls (o_busy) under debug halt or a full trace FIFO.
module cpu_writeback
    import cpu_writeback_pkg::*;
#(
    parameter int TRACE_DEPTH   = 4,
    parameter int INSTRET_WIDTH = 64
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  memory_data_t             i_data,
    output logic                     o_busy,
    input  logic                     i_halt,
    output logic                     o_rd_we,
    output logic [4:0]               o_rd_index,
    output logic [31:0]              o_rd_value,
    output logic                     o_fwd_valid,
    output logic [4:0]               o_fwd_index,
    output logic [31:0]              o_fwd_value,
    output logic [INSTRET_WIDTH-1:0] o_instret,
    input  logic                     i_instret_we,
    input  logic [INSTRET_WIDTH-1:0] i_instret_wdata,
    output logic                     o_trace_valid,
    input  logic                     i_trace_ready,
    output logic [31:0]              o_trace_pc,
    output logic [4:0]               o_trace_rd_index,
    output logic [31:0]              o_trace_rd_value
);

    logic                     last_strobe_q, last_strobe_d;
    logic                     rd_we_q, rd_we_d;
    reg_index_t               rd_index_q, rd_index_d;
    register_t                rd_value_q, rd_value_d;
    logic                     fwd_valid_q, fwd_valid_d;
    reg_index_t               fwd_index_q, fwd_index_d;
    register_t                fwd_value_q, fwd_value_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic          pending;
    logic          accept;
    logic          trace_full;
    trace_record_t push_rec;

    assign pending  = (i_data.strobe != last_strobe_q);
    assign accept   = pending && !i_halt && !trace_full;
    assign o_busy   = pending && !accept;
    assign push_rec = '{pc: i_data.pc, rd_index: i_data.inst_rd, rd_value: i_data.rd};

    generate
        if (TRACE_DEPTH > 0) begin : g_trace
            logic [TRACE_REC_W-1:0] head_dat;
            trace_record_t          head;

            cpu_trace_fifo #(
                .DEPTH (TRACE_DEPTH),
                .WIDTH (TRACE_REC_W)
            ) u_trace_fifo (
                .i_clock    (i_clock),
                .i_reset    (i_reset),
                .i_push_vld (accept),
                .i_push_dat (push_rec),
                .o_full     (trace_full),
                .o_pop_vld  (o_trace_valid),
                .i_pop_rdy  (i_trace_ready),
                .o_pop_dat  (head_dat)
            );

            assign head             = trace_record_t'(head_dat);
            assign o_trace_pc       = head.pc;
            assign o_trace_rd_index = head.rd_index;
            assign o_trace_rd_value = head.rd_value;
        end else begin : g_no_trace
            assign trace_full       = 1'b0;
            assign o_trace_valid    = 1'b0;
            assign o_trace_pc       = '0;
            assign o_trace_rd_index = '0;
            assign o_trace_rd_value = '0;
        end
    endgenerate

    always_comb begin
        last_strobe_d = last_strobe_q;
        rd_we_d       = 1'b0;
        rd_index_d    = rd_index_q;
        rd_value_d    = rd_value_q;
        fwd_valid_d   = fwd_valid_q;
        fwd_index_d   = fwd_index_q;
        fwd_value_d   = fwd_value_q;
        instret_d     = instret_q;
        if (accept) begin
            last_strobe_d = i_data.strobe;
            rd_we_d       = (i_data.inst_rd != '0);
            rd_index_d    = i_data.inst_rd;
            rd_value_d    = i_data.rd;
            // x0 retires without disturbing the forwarding entry
            if (i_data.inst_rd != '0) begin
                fwd_valid_d = 1'b1;
                fwd_index_d = i_data.inst_rd;
                fwd_value_d = i_data.rd;
            end
        end
        if (i_instret_we) begin
            instret_d = i_instret_wdata;
        end else if (accept) begin
            instret_d = instret_q + INSTRET_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            last_strobe_q <= 1'b0;
            rd_we_q       <= 1'b0;
            rd_index_q    <= '0;
            rd_value_q    <= '0;
            fwd_valid_q   <= 1'b0;
            fwd_index_q   <= '0;
            fwd_value_q   <= '0;
            instret_q     <= '0;
        end else begin
            last_strobe_q <= last_strobe_d;
            rd_we_q       <= rd_we_d;
            rd_index_q    <= rd_index_d;
            rd_value_q    <= rd_value_d;
            fwd_valid_q   <= fwd_valid_d;
            fwd_index_q   <= fwd_index_d;
            fwd_value_q   <= fwd_value_d;
            instret_q     <= instret_d;
        end
    end

    assign o_rd_we     = rd_we_q;
    assign o_rd_index  = rd_index_q;
    assign o_rd_value  = rd_value_q;
    assign o_fwd_valid = fwd_valid_q;
    assign o_fwd_index = fwd_index_q;
    assign o_fwd_value = fwd_value_q;
    assign o_instret   = instret_q;

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Final pipeline stage, directly downstream of the memory stage. Consumes the memory_data_t packet (pc, rd, inst_rd, strobe) on the toggle-strobe handshake.
- Retires each instruction: drives the register file write port, keeps a registered forwarding copy of the last write, and counts retired instructions (instret).
- Pushes a retire record into a small trace FIFO that the debug unit drains.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries; power of two; 0 removes the FIFO (trace outputs tied 0, never back-pressures).
- INSTRET_WIDTH, 64, retire counter width.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_data  in  memory_data_t  packet from memory stage; new packet when i_data.strobe != internal last_strobe
- o_busy  out  1  new packet pending but not accepted this cycle
- i_halt  in  1  debug halt; blocks acceptance
- o_rd_we  out  1  register file write enable, one-cycle pulse
- o_rd_index  out  5  register file write index
- o_rd_value  out  32  register file write data
- o_fwd_valid  out  1  forwarding entry valid
- o_fwd_index  out  5  last written register
- o_fwd_value  out  32  last written value
- o_instret  out  INSTRET_WIDTH  retired instruction count
- i_instret_we  in  1  CSR write to instret
- i_instret_wdata  in  INSTRET_WIDTH  CSR write data
- o_trace_valid  out  1  trace FIFO non-empty
- i_trace_ready  in  1  consumer pops head when o_trace_valid && i_trace_ready
- o_trace_pc  out  32  head record pc
- o_trace_rd_index  out  5  head record inst_rd
- o_trace_rd_value  out  32  head record rd

Behaviour:
- Reset: last_strobe=0; o_rd_we=0; index/value 0; o_fwd_*=0; o_instret=0; FIFO empty (count 0, ptrs 0); o_trace_valid=0. A pending packet is dropped (upstream resets its strobe to 0 in the same cycle).
- pending = (i_data.strobe != last_strobe).
- accept = pending && !i_halt && !(TRACE_DEPTH>0 && fifo_full).
- fifo_full uses the registered count. A same-cycle pop does not free a slot for a push.
- o_busy = pending && !accept (combinational).
- On accept in cycle N, at edge N+1:
  - last_strobe <= i_data.strobe.
  - o_rd_we <= (inst_rd != 0); o_rd_index <= inst_rd; o_rd_value <= rd.
  - If inst_rd != 0: o_fwd_valid <= 1 and o_fwd_index/value updated. Otherwise forwarding is unchanged.
  - o_instret <= o_instret + 1, wrapping at all-ones to 0.
  - Push {pc, inst_rd, rd} into the FIFO.
- o_rd_we is 0 in every cycle without an accept on the previous edge. Throughput is one packet per clock.
- Writes to x0 are suppressed but the instruction still retires: it counts and is traced.
- instret: if i_instret_we, o_instret <= i_instret_wdata and a simultaneous retire is not added (CSR write wins).
- FIFO:
  - Synchronous, registered head outputs.
  - Pop and push in the same cycle when not full: count unchanged, both pointers advance.
  - Pop when empty is ignored.
  - Pointers wrap modulo TRACE_DEPTH.
  - o_trace_* hold their value while !i_trace_ready.
- i_halt asserted mid-stream: the packet waits with o_busy=1. It is accepted on the first cycle halt is low.

Decomposition:
- memory_data_t and register_t are shared from the CPU types package. Add trace_record_t {pc, rd_index, rd_value} there for the debug unit.
- One natural sub-module, cpu_trace_fifo: parameterised depth/width, synchronous FIFO with count-based full/empty. It is instantiated only when TRACE_DEPTH > 0.

Test Plan:
- Toggle strobe with pc=0x100, inst_rd=5, rd=0xDEADBEEF -> next edge o_rd_we=1, index 5, value 0xDEADBEEF; o_fwd = {1,5,0xDEADBEEF}; o_instret=1; trace head pc=0x100; o_busy stays 0.
- Packet with inst_rd=0, rd=0x1234 -> o_rd_we=0; forwarding unchanged; o_instret increments; trace record {pc, 0, 0x1234} present.
- Back-to-back toggles each cycle, i_trace_ready=1, TRACE_DEPTH=4 -> one retire per clock, no o_busy, 8 packets give o_instret=8.
- i_trace_ready=0, 5 packets -> first 4 accepted. Fifth holds o_busy=1 until one pop; it is accepted the cycle after the pop, not the pop cycle.
- i_halt=1 with a pending packet for 3 cycles -> o_busy=1, no write. Release -> accept next cycle.
- o_instret=all-ones, then a retire -> 0. Simultaneous i_instret_we with wdata=0x10 and a retire -> 0x10. Assert reset while a packet is pending -> all outputs 0, packet dropped.
